regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port among NREQ writeback requesters (ALU, load unit, CSR/mul path).
//  Round-robin arbitration with a valid/ready handshake; winner drives we/waddr/wdata into the register file.
//  Sits between the writeback-stage producers and regfile; it is the register file's only write master.
// PARAMETERS
//  NREQ      2    number of writeback requesters (2..8)
//  PTR_W     3    width of round-robin pointer; must satisfy 2**PTR_W >= NREQ
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst        in   1           asynchronous, active-low reset (asserted at 0)
//  flush      in   1           synchronous: drop pending grant/output, pointer kept
//  req_valid  in   NREQ        requester i has a write pending
//  req_waddr  in   NREQ*5      requester i dest register, slice [5i+4:5i]
//  req_wdata  in   NREQ*32     requester i data, slice [32i+31:32i]
//  req_ready  out  NREQ        one-hot grant; transfer on valid&ready
//  we         out  1           register file write enable (WriteEnable = 1)
//  waddr      out  5           register file write address (RegAddrBus)
//  wdata      out  32          register file write data (RegBus)
//  rr_ptr     out  PTR_W       current highest-priority requester index (debug)
// BEHAVIOUR
//  - Reset (rst=0, async): rr_ptr=0, req_ready=0, we=0, waddr=0, wdata=0.
//  - Arbitration each cycle: search i = rr_ptr, rr_ptr+1, ... mod NREQ; first valid wins.
//  - req_ready = one-hot of winner; at most one bit set; 0 when no valid or flush=1.
//  - Requester must hold valid/waddr/wdata stable until ready; dropping valid early is illegal (assertion).
//  - On transfer: rr_ptr <= (winner+1) mod NREQ; no transfer -> rr_ptr unchanged. Wrap at NREQ-1 -> 0.
//  - Max wait for a continuously valid requester: NREQ-1 transfers (starvation-free).
//  - Writes to x0: handshake completes (ready=1, pointer advances) but we=0.
//  - Same waddr from two requesters same cycle: only winner written; loser retries next cycle (later data wins).
//  - flush=1: no grant that cycle; with output register, pending write is cancelled (we=0 next cycle).
//  - Reset mid-operation: in-flight grant discarded; requesters must re-present after reset.
//  - Register file never back-pressures; no FSM beyond pointer (and output stage when enabled).
// CONFIGURATION
//  - REGFILE_WB_OUTREG_EN defined: we/waddr/wdata registered; latency 1 cycle from transfer to write;
//    regfile bypass path sees data one cycle later; flush clears the registered we.
//  - Undefined: we/waddr/wdata combinational from winner, same-cycle write; latency 0.
// STRUCTURE
//  - Widths/values from defines.v: RegAddrBus, RegBus, ZeroWord, WriteEnable/WriteDisable, RegNumLog2.
//    Add RstEnable_N (1'b0) there for the active-low reset level.
//  - One sub-module: rr_pick (NREQ-wide rotate-priority encoder: valid vector + ptr -> one-hot + index + any).
// TESTING
//  - Reset: hold rst=0 with all valid=1 -> ready=0, we=0, rr_ptr=0; release -> grant req0 first cycle.
//  - Fairness: NREQ=2, both valid 6 cycles -> grants 0,1,0,1,0,1; rr_ptr toggles 1,0,1,...
//  - x0 write: req0 valid waddr=0 wdata=32'hDEAD -> ready[0]=1, we=0, rr_ptr advances to 1.
//  - Collision: req0/req1 both waddr=5 data 'h11/'h22, ptr=0 -> x5='h11 then x5='h22 next cycle.
//  - Flush: req1 valid, flush=1 one cycle -> ready=0, we=0 (OUTREG: registered we cleared); granted cycle after.
//  - Latency: with REGFILE_WB_OUTREG_EN, transfer at cycle t -> we=1 at t+1; without, we=1 at t.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, constant values and the writeback record type for the
// register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int          REG_NUM_LOG2  = 5;
  localparam int          REG_ADDR_W    = REG_NUM_LOG2;
  localparam int          REG_W         = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic        RST_ENABLE_N  = 1'b0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_W-1:0]      wdata;
  } wb_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Rotate-priority encoder: the first valid requester at or after ptr
// (wrapping modulo NREQ) wins; reports one-hot grant, index and any-valid.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 3
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  always_comb begin : pick
    int unsigned j;
    // NOTE: every output gets a default before the search so no path leaves
    // a value held over from a previous evaluation, which would infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        idx      = PTR_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NREQ writeback requesters. Define REGFILE_WB_OUTREG_EN to register
// we/waddr/wdata (one cycle latency); otherwise the write is same-cycle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*REG_ADDR_W-1:0] req_waddr,
  input  logic [NREQ*REG_W-1:0]      req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic                       we,
  output logic [REG_ADDR_W-1:0]      waddr,
  output logic [REG_W-1:0]           wdata,
  output logic [PTR_W-1:0]           rr_ptr
);

  logic [NREQ-1:0]  pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             rst_active;
  logic             xfer;
  logic [PTR_W-1:0] next_ptr;
  wb_t              wb_next;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grants are suppressed while reset is held so nothing is accepted in that window.
  assign rst_active = (rst == RST_ENABLE_N);
  assign xfer       = pick_any & ~flush & ~rst_active;
  assign req_ready  = xfer ? pick_grant : '0;
  assign next_ptr   = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst == RST_ENABLE_N) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= next_ptr;
    end
  end

  // A write to x0 still completes the handshake but never enables the port.
  always_comb begin
    wb_next       = '0;
    wb_next.we    = WRITE_DISABLE;
    wb_next.wdata = ZERO_WORD;
    if (xfer) begin
      wb_next.waddr = req_waddr[int'(pick_idx)*REG_ADDR_W +: REG_ADDR_W];
      wb_next.wdata = req_wdata[int'(pick_idx)*REG_W +: REG_W];
      wb_next.we    = (wb_next.waddr != '0) ? WRITE_ENABLE : WRITE_DISABLE;
    end
  end

`ifdef REGFILE_WB_OUTREG_EN
  wb_t wb_q;

  // A flush cycle has no transfer, so the register loads a disabled write.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_next;
    end
  end

  assign we    = wb_q.we;
  assign waddr = wb_q.waddr;
  assign wdata = wb_q.wdata;
`else
  assign we    = wb_next.we;
  assign waddr = wb_next.waddr;
  assign wdata = wb_next.wdata;
`endif

  // Requesters must hold valid, address and data until granted.
  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_hold : assert property (
      @(posedge clk) disable iff (rst == RST_ENABLE_N)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] &&
         $stable(req_waddr[i*REG_ADDR_W +: REG_ADDR_W]) &&
         $stable(req_wdata[i*REG_W +: REG_W]))
    );
  end

endmodule
